mem_wb_stage: RTL and testbench

- Memory-access plus write-back stage directly downstream of the execute datapath.
- Consumes the execute outputs: ALU/post-ALU result, store data, destination register, and the regWrite/memToReg/memWrite/PCSrc controls.
- Drives a handshaked data-memory port and returns resultW, WA3W, regWriteW and PCSrcW to the register file and PC mux.
- Raises memStall, which upstream ORs into stallF and the execute-register enable, while a memory access is outstanding.

---
 rtl/proc_pkg.sv | 13 +
 rtl/mem_wb_stage_if.sv | 12 +
 rtl/mem_access_fsm.sv | 39 +++
 rtl/mem_wb_stage.sv | 77 +++++++
 tb/tb_mem_wb_stage.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/proc_pkg.sv
// proc_pkg: shared widths, memory FSM states and pipeline control bundle
package proc_pkg;
  localparam int DATA_W = 24;
  localparam int ADDR_W = 16;
  localparam int REG_W = 4;
  typedef enum logic {IDLE, WAIT} mem_state_t;
  typedef struct packed {
    logic regWrite;
    logic memToReg;
    logic memWrite;
    logic PCSrc;
  } mem_ctrl_t;
endpackage

// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: handshaked data-memory port between the stage and memory
interface mem_wb_stage_if;
  import proc_pkg::*;
  logic memReq;
  logic memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWdata;
  logic [DATA_W-1:0] memRdata;
  logic memAck;
  modport master(output memReq, memWe, memAddr, memWdata, input memRdata, memAck);
  modport slave(input memReq, memWe, memAddr, memWdata, output memRdata, memAck);
endinterface

// File: rtl/mem_access_fsm.sv
// mem_access_fsm: request/stall sequencing with timeout and sticky error
module mem_access_fsm
  import proc_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic access,
  input  logic ack,
  output logic req,
  output logic stall,
  output logic timeout,
  output logic err
);
  mem_state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  // An access stalls until acked or the wait budget runs out; ack beats timeout
  always_comb begin
    req = access | (state == WAIT);
    timeout = (state == WAIT) && !ack && (cnt == CNT_W'(TIMEOUT));
    stall = req & !ack & !timeout;
    state_n = stall ? WAIT : IDLE;
    cnt_n = stall ? ((state == WAIT) ? cnt + 1'b1 : CNT_W'(1)) : '0;
  end
  // State, wait counter and sticky timeout flag; reset abandons any access
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      err <= err | timeout;
    end
  end
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory-access and write-back pipeline stage
module mem_wb_stage
  import proc_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic [ADDR_W-1:0] aluResE,
  input  logic [DATA_W-1:0] writeDataE,
  input  logic [REG_W-1:0] WA3E,
  input  logic regWriteE,
  input  logic memToRegE,
  input  logic memWriteE,
  input  logic PCSrcE,
  mem_wb_stage_if.master mem,
  output logic memStall,
  output logic memErr,
  output logic [DATA_W-1:0] resultW,
  output logic [REG_W-1:0] WA3W,
  output logic regWriteW,
  output logic PCSrcW
);
  mem_ctrl_t ctrlM;
  logic [ADDR_W-1:0] aluResM;
  logic [DATA_W-1:0] writeDataM;
  logic [REG_W-1:0] WA3M;
  logic req, timeout;
  logic [DATA_W-1:0] result_m;
  mem_access_fsm #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_fsm (
    .clk(clk),
    .rst(rst),
    .access(ctrlM.memToReg | ctrlM.memWrite),
    .ack(mem.memAck),
    .req(req),
    .stall(memStall),
    .timeout(timeout),
    .err(memErr)
  );
  assign mem.memReq = req;
  assign mem.memWe = ctrlM.memWrite;
  assign mem.memAddr = aluResM;
  assign mem.memWdata = writeDataM;
  // Store wins over load when both are set, so only pure loads take memory data
  always_comb begin
    result_m = (ctrlM.memToReg & !ctrlM.memWrite) ? (timeout ? '0 : mem.memRdata) : DATA_W'(aluResM);
  end
  // M register holds the instruction for the whole access
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrlM <= '0;
      aluResM <= '0;
      writeDataM <= '0;
      WA3M <= '0;
    end else if (!memStall) begin
      ctrlM <= '{regWriteE, memToRegE, memWriteE, PCSrcE};
      aluResM <= aluResE;
      writeDataM <= writeDataE;
      WA3M <= WA3E;
    end
  end
  // W register takes the completing instruction, or a bubble while stalled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resultW <= '0;
      WA3W <= '0;
      regWriteW <= 1'b0;
      PCSrcW <= 1'b0;
    end else begin
      resultW <= memStall ? resultW : result_m;
      WA3W <= memStall ? WA3W : WA3M;
      regWriteW <= !memStall & ctrlM.regWrite;
      PCSrcW <= !memStall & ctrlM.PCSrc;
    end
  end
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed checks of the memory/write-back stage
module tb_mem_wb_stage;
  logic clk;
  logic rst;
  logic [15:0] aluResE;
  logic [23:0] writeDataE;
  logic [3:0] WA3E;
  logic regWriteE, memToRegE, memWriteE, PCSrcE;
  logic memStall, memErr, regWriteW, PCSrcW;
  logic [23:0] resultW;
  logic [3:0] WA3W;
  int n_cmp = 0;
  int n_bad = 0;
  mem_wb_stage_if m();
  mem_wb_stage dut (
    .clk(clk), .rst(rst), .aluResE(aluResE), .writeDataE(writeDataE), .WA3E(WA3E),
    .regWriteE(regWriteE), .memToRegE(memToRegE), .memWriteE(memWriteE), .PCSrcE(PCSrcE),
    .mem(m.master), .memStall(memStall), .memErr(memErr), .resultW(resultW),
    .WA3W(WA3W), .regWriteW(regWriteW), .PCSrcW(PCSrcW)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic set_e(input logic [15:0] a, input logic [23:0] d, input logic [3:0] w,
                       input logic rw, input logic mr, input logic mw, input logic pc);
    aluResE = a; writeDataE = d; WA3E = w;
    regWriteE = rw; memToRegE = mr; memWriteE = mw; PCSrcE = pc;
  endtask
  task automatic nop();
    set_e(16'h0, 24'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic test_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    n_cmp++; if (m.memReq !== 1'b0) begin n_bad++; $display("FAIL reset_memReq got %b exp 0", m.memReq); end
    n_cmp++; if (memStall !== 1'b0) begin n_bad++; $display("FAIL reset_memStall got %b exp 0", memStall); end
    n_cmp++; if (regWriteW !== 1'b0) begin n_bad++; $display("FAIL reset_regWriteW got %b exp 0", regWriteW); end
    n_cmp++; if (PCSrcW !== 1'b0) begin n_bad++; $display("FAIL reset_PCSrcW got %b exp 0", PCSrcW); end
    n_cmp++; if (resultW !== 24'h0) begin n_bad++; $display("FAIL reset_resultW got %h exp 0", resultW); end
    n_cmp++; if (WA3W !== 4'h0) begin n_bad++; $display("FAIL reset_WA3W got %h exp 0", WA3W); end
    n_cmp++; if (memErr !== 1'b0) begin n_bad++; $display("FAIL reset_memErr got %b exp 0", memErr); end
    @(negedge clk) rst = 1'b1;
    step();
  endtask
  task automatic test_alu();
    set_e(16'h1234, 24'h0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    nop();
    @(negedge clk);
    n_cmp++; if (m.memReq !== 1'b0) begin n_bad++; $display("FAIL alu_memReq got %b exp 0", m.memReq); end
    step();
    @(negedge clk);
    n_cmp++; if (resultW !== 24'h001234) begin n_bad++; $display("FAIL alu_resultW got %h exp 001234", resultW); end
    n_cmp++; if (WA3W !== 4'd5) begin n_bad++; $display("FAIL alu_WA3W got %h exp 5", WA3W); end
    n_cmp++; if (regWriteW !== 1'b1) begin n_bad++; $display("FAIL alu_regWriteW got %b exp 1", regWriteW); end
    step();
    @(negedge clk);
    n_cmp++; if (regWriteW !== 1'b0) begin n_bad++; $display("FAIL alu_single_wb got %b exp 0", regWriteW); end
  endtask
  task automatic test_load_zero_wait();
    set_e(16'h0010, 24'h0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    nop();
    m.memAck = 1'b1; m.memRdata = 24'hABCDEF;
    @(negedge clk);
    n_cmp++; if (m.memReq !== 1'b1) begin n_bad++; $display("FAIL ld0_memReq got %b exp 1", m.memReq); end
    n_cmp++; if (m.memWe !== 1'b0) begin n_bad++; $display("FAIL ld0_memWe got %b exp 0", m.memWe); end
    n_cmp++; if (m.memAddr !== 16'h0010) begin n_bad++; $display("FAIL ld0_memAddr got %h exp 0010", m.memAddr); end
    n_cmp++; if (memStall !== 1'b0) begin n_bad++; $display("FAIL ld0_memStall got %b exp 0", memStall); end
    step();
    m.memAck = 1'b0; m.memRdata = 24'h0;
    @(negedge clk);
    n_cmp++; if (resultW !== 24'hABCDEF) begin n_bad++; $display("FAIL ld0_resultW got %h exp abcdef", resultW); end
    n_cmp++; if (regWriteW !== 1'b1) begin n_bad++; $display("FAIL ld0_regWriteW got %b exp 1", regWriteW); end
    n_cmp++; if (WA3W !== 4'd3) begin n_bad++; $display("FAIL ld0_WA3W got %h exp 3", WA3W); end
  endtask
  task automatic test_store_wait();
    set_e(16'h0077, 24'h0, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    set_e(16'h0040, 24'h00FF00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    nop();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (m.memReq !== 1'b1) begin n_bad++; $display("FAIL st_memReq[%0d] got %b exp 1", i, m.memReq); end
      n_cmp++; if (m.memWe !== 1'b1) begin n_bad++; $display("FAIL st_memWe[%0d] got %b exp 1", i, m.memWe); end
      n_cmp++; if (m.memAddr !== 16'h0040) begin n_bad++; $display("FAIL st_memAddr[%0d] got %h exp 0040", i, m.memAddr); end
      n_cmp++; if (m.memWdata !== 24'h00FF00) begin n_bad++; $display("FAIL st_memWdata[%0d] got %h exp 00ff00", i, m.memWdata); end
      n_cmp++; if (memStall !== 1'b1) begin n_bad++; $display("FAIL st_memStall[%0d] got %b exp 1", i, memStall); end
      n_cmp++; if (regWriteW !== (i == 0)) begin n_bad++; $display("FAIL st_bubble[%0d] got %b exp %b", i, regWriteW, i == 0); end
      step();
    end
    m.memAck = 1'b1;
    @(negedge clk);
    n_cmp++; if (m.memReq !== 1'b1) begin n_bad++; $display("FAIL st_ack_memReq got %b exp 1", m.memReq); end
    n_cmp++; if (m.memAddr !== 16'h0040) begin n_bad++; $display("FAIL st_ack_memAddr got %h exp 0040", m.memAddr); end
    n_cmp++; if (memStall !== 1'b0) begin n_bad++; $display("FAIL st_ack_memStall got %b exp 0", memStall); end
    step();
    m.memAck = 1'b0;
    @(negedge clk);
    n_cmp++; if (m.memReq !== 1'b0) begin n_bad++; $display("FAIL st_no_reissue got %b exp 0", m.memReq); end
    n_cmp++; if (regWriteW !== 1'b0) begin n_bad++; $display("FAIL st_regWriteW got %b exp 0", regWriteW); end
  endtask
  task automatic test_pcsrc();
    set_e(16'h0100, 24'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    nop();
    step();
    @(negedge clk);
    n_cmp++; if (PCSrcW !== 1'b1) begin n_bad++; $display("FAIL pc_PCSrcW got %b exp 1", PCSrcW); end
    n_cmp++; if (resultW[15:0] !== 16'h0100) begin n_bad++; $display("FAIL pc_target got %h exp 0100", resultW[15:0]); end
    step();
    @(negedge clk);
    n_cmp++; if (PCSrcW !== 1'b0) begin n_bad++; $display("FAIL pc_pulse got %b exp 0", PCSrcW); end
  endtask
  task automatic test_back_to_back();
    set_e(16'h0050, 24'h0, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    set_e(16'h0060, 24'h0, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    n_cmp++; if (memStall !== 1'b1) begin n_bad++; $display("FAIL b2b_stall1 got %b exp 1", memStall); end
    step();
    m.memAck = 1'b1; m.memRdata = 24'h111111;
    @(negedge clk);
    n_cmp++; if (memStall !== 1'b0) begin n_bad++; $display("FAIL b2b_done1 got %b exp 0", memStall); end
    n_cmp++; if (m.memAddr !== 16'h0050) begin n_bad++; $display("FAIL b2b_addr1 got %h exp 0050", m.memAddr); end
    step();
    nop();
    m.memAck = 1'b0;
    @(negedge clk);
    n_cmp++; if (m.memReq !== 1'b1) begin n_bad++; $display("FAIL b2b_req2 got %b exp 1", m.memReq); end
    n_cmp++; if (m.memAddr !== 16'h0060) begin n_bad++; $display("FAIL b2b_addr2 got %h exp 0060", m.memAddr); end
    n_cmp++; if (memStall !== 1'b1) begin n_bad++; $display("FAIL b2b_stall2 got %b exp 1", memStall); end
    n_cmp++; if (resultW !== 24'h111111) begin n_bad++; $display("FAIL b2b_result1 got %h exp 111111", resultW); end
    n_cmp++; if (WA3W !== 4'd1) begin n_bad++; $display("FAIL b2b_WA3W1 got %h exp 1", WA3W); end
    n_cmp++; if (regWriteW !== 1'b1) begin n_bad++; $display("FAIL b2b_regWriteW1 got %b exp 1", regWriteW); end
    m.memAck = 1'b1; m.memRdata = 24'h222222;
    #1;
    n_cmp++; if (memStall !== 1'b0) begin n_bad++; $display("FAIL b2b_done2 got %b exp 0", memStall); end
    step();
    m.memAck = 1'b0;
    @(negedge clk);
    n_cmp++; if (resultW !== 24'h222222) begin n_bad++; $display("FAIL b2b_result2 got %h exp 222222", resultW); end
    n_cmp++; if (WA3W !== 4'd4) begin n_bad++; $display("FAIL b2b_WA3W2 got %h exp 4", WA3W); end
    n_cmp++; if (m.memReq !== 1'b0) begin n_bad++; $display("FAIL b2b_no_reissue got %b exp 0", m.memReq); end
  endtask
  task automatic test_ack_at_timeout();
    set_e(16'h0020, 24'h0, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    nop();
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      n_cmp++; if (memStall !== 1'b1) begin n_bad++; $display("FAIL ackto_stall[%0d] got %b exp 1", i, memStall); end
      step();
    end
    m.memAck = 1'b1; m.memRdata = 24'h13579B;
    @(negedge clk);
    n_cmp++; if (memStall !== 1'b0) begin n_bad++; $display("FAIL ackto_done got %b exp 0", memStall); end
    step();
    m.memAck = 1'b0;
    @(negedge clk);
    n_cmp++; if (resultW !== 24'h13579B) begin n_bad++; $display("FAIL ackto_resultW got %h exp 13579b", resultW); end
    n_cmp++; if (memErr !== 1'b0) begin n_bad++; $display("FAIL ackto_memErr got %b exp 0", memErr); end
    n_cmp++; if (regWriteW !== 1'b1) begin n_bad++; $display("FAIL ackto_regWriteW got %b exp 1", regWriteW); end
  endtask
  task automatic test_timeout();
    set_e(16'h0020, 24'h0, 4'd8, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    nop();
    m.memRdata = 24'h555555;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      n_cmp++; if (memStall !== 1'b1) begin n_bad++; $display("FAIL to_stall[%0d] got %b exp 1", i, memStall); end
      step();
    end
    @(negedge clk);
    n_cmp++; if (memStall !== 1'b0) begin n_bad++; $display("FAIL to_done got %b exp 0", memStall); end
    n_cmp++; if (m.memReq !== 1'b1) begin n_bad++; $display("FAIL to_memReq got %b exp 1", m.memReq); end
    step();
    @(negedge clk);
    n_cmp++; if (resultW !== 24'h0) begin n_bad++; $display("FAIL to_resultW got %h exp 0", resultW); end
    n_cmp++; if (WA3W !== 4'd8) begin n_bad++; $display("FAIL to_WA3W got %h exp 8", WA3W); end
    n_cmp++; if (regWriteW !== 1'b1) begin n_bad++; $display("FAIL to_regWriteW got %b exp 1", regWriteW); end
    n_cmp++; if (memErr !== 1'b1) begin n_bad++; $display("FAIL to_memErr got %b exp 1", memErr); end
    m.memRdata = 24'h0;
    set_e(16'h0011, 24'h0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    nop();
    step();
    @(negedge clk);
    n_cmp++; if (resultW !== 24'h000011) begin n_bad++; $display("FAIL to_next_resultW got %h exp 000011", resultW); end
    n_cmp++; if (memErr !== 1'b1) begin n_bad++; $display("FAIL to_sticky got %b exp 1", memErr); end
  endtask
  task automatic test_reset_in_wait();
    set_e(16'h0030, 24'h0, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    nop();
    step();
    step();
    @(negedge clk);
    n_cmp++; if (memStall !== 1'b1) begin n_bad++; $display("FAIL rw_pre_stall got %b exp 1", memStall); end
    rst = 1'b0;
    #1;
    n_cmp++; if (m.memReq !== 1'b0) begin n_bad++; $display("FAIL rw_memReq got %b exp 0", m.memReq); end
    n_cmp++; if (memStall !== 1'b0) begin n_bad++; $display("FAIL rw_memStall got %b exp 0", memStall); end
    n_cmp++; if (regWriteW !== 1'b0) begin n_bad++; $display("FAIL rw_regWriteW got %b exp 0", regWriteW); end
    n_cmp++; if (memErr !== 1'b0) begin n_bad++; $display("FAIL rw_memErr got %b exp 0", memErr); end
    #1 rst = 1'b1;
    step();
    set_e(16'h0ABC, 24'h0, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    nop();
    @(negedge clk);
    n_cmp++; if (m.memReq !== 1'b0) begin n_bad++; $display("FAIL rw_no_reissue got %b exp 0", m.memReq); end
    step();
    @(negedge clk);
    n_cmp++; if (resultW !== 24'h000ABC) begin n_bad++; $display("FAIL rw_resultW got %h exp 000abc", resultW); end
    n_cmp++; if (WA3W !== 4'd9) begin n_bad++; $display("FAIL rw_WA3W got %h exp 9", WA3W); end
    n_cmp++; if (regWriteW !== 1'b1) begin n_bad++; $display("FAIL rw_regWriteW_after got %b exp 1", regWriteW); end
  endtask
  initial begin
    nop();
    m.memAck = 1'b0;
    m.memRdata = 24'h0;
    test_reset();
    test_alu();
    test_load_zero_wait();
    test_store_wait();
    test_pcsrc();
    test_back_to_back();
    test_ack_at_timeout();
    test_timeout();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
